// File: rtl/beep_pkg.sv
// Shared types and pitch/cadence helpers for the buzzer tone generator.
// Helpers take the block parameters as arguments so one package serves every instance.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_e;

  // Tone half-period in clk cycles; higher level means shorter half-period (higher pitch).
  function automatic int unsigned half_of(input int unsigned lvl,
                                          input int unsigned sat,
                                          input int unsigned base,
                                          input int unsigned step);
    if (lvl >= sat) begin
      return base;
    end
    return base + step * (sat - lvl);
  endfunction

  // Cadence silence in clk cycles; halves with each level step, never below one cycle.
  function automatic int unsigned off_of(input int unsigned lvl,
                                         input int unsigned off_base);
    int unsigned sh;
    if (lvl == 0) begin
      sh = off_base;
    end else begin
      sh = off_base >> (lvl - 1);
    end
    return (sh == 0) ? 1 : sh;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Programmable half-period square-wave divider. The output flop is the buzzer drive;
// restart forces a fresh full-length high phase, and dropping en parks the output low.
module tone_div #(
  parameter int TONE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              en,
  input  logic [TONE_W-1:0] half,
  output logic              tone,
  output logic              period_end
);

  logic [TONE_W-1:0] cnt_q;
  logic [TONE_W-1:0] cnt_d;
  logic              tone_q;
  logic              tone_d;
  logic              wrap;

  assign wrap = (cnt_q == half - TONE_W'(1));

  // Raw 0->1 boundary marker; it is only meaningful while the caller keeps en high.
  assign period_end = wrap && !tone_q;
  assign tone       = tone_q;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tone_d = !tone_q;
      end else begin
        cnt_d = cnt_q + TONE_W'(1);
      end
    end else begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

endmodule

// File: rtl/beep_cadence.sv
// Alarm-level buzzer driver: level sets pitch, optional on/off cadence whose silence
// shrinks as level rises. Pitch only changes on full tone-period boundaries.
module beep_cadence
  import beep_pkg::*;
#(
  parameter int LEVEL_W   = 3,
  parameter int SAT_LEVEL = 6,
  parameter int BASE_HALF = 2,
  parameter int STEP_HALF = 1,
  parameter int TONE_W    = 16,
  parameter int ON_CYC    = 1000,
  parameter int OFF_BASE  = 4000,
  parameter int CAD_W     = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beep_en,
  input  logic [LEVEL_W-1:0] level,
  input  logic               mode,
  output logic               beep_out,
  output logic               active,
  output logic [1:0]         dbg_state
);

  localparam logic [LEVEL_W-1:0] SAT_L   = LEVEL_W'(SAT_LEVEL);
  localparam logic [CAD_W-1:0]   ON_LAST = CAD_W'(ON_CYC - 1);

  beep_state_e        state_q;
  beep_state_e        state_d;
  logic [LEVEL_W-1:0] cur_lvl_q;
  logic [LEVEL_W-1:0] cur_lvl_d;
  logic               cur_mode_q;
  logic               cur_mode_d;
  logic [CAD_W-1:0]   cad_cnt_q;
  logic [CAD_W-1:0]   cad_cnt_d;

  logic [LEVEL_W-1:0] eff;
  logic               run;
  logic [TONE_W-1:0]  half;
  logic [CAD_W-1:0]   off_last;
  logic               tone_restart;
  logic               tone_en;
  logic               tone;
  logic               period_end;

  assign eff      = (level > SAT_L) ? SAT_L : level;
  assign run      = beep_en && (eff != '0);
  assign half     = TONE_W'(half_of(32'(cur_lvl_q), SAT_LEVEL, BASE_HALF, STEP_HALF));
  assign off_last = CAD_W'(off_of(32'(cur_lvl_q), OFF_BASE) - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_lvl_q  <= '0;
      cur_mode_q <= 1'b0;
      cad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_lvl_q  <= cur_lvl_d;
      cur_mode_q <= cur_mode_d;
      cad_cnt_q  <= cad_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_lvl_d  = cur_lvl_q;
    cur_mode_d = cur_mode_q;
    cad_cnt_d  = cad_cnt_q;
    if (!run) begin
      state_d   = IDLE;
      cad_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = ON;
          cur_lvl_d  = eff;
          cur_mode_d = mode;
          cad_cnt_d  = '0;
        end
        ON: begin
          if (cur_mode_q) begin
            if (cad_cnt_q == ON_LAST) begin
              state_d   = OFF;
              cad_cnt_d = '0;
            end else begin
              cad_cnt_d = cad_cnt_q + CAD_W'(1);
            end
          end
          // Cadence end suppresses the toggle, so the level reload waits for next ON.
          if (state_d == ON && period_end) begin
            cur_lvl_d = eff;
          end
        end
        OFF: begin
          if (cad_cnt_q == off_last) begin
            state_d    = ON;
            cad_cnt_d  = '0;
            cur_lvl_d  = eff;
            cur_mode_d = mode;
          end else begin
            cad_cnt_d = cad_cnt_q + CAD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tone_restart = (state_q != ON) && (state_d == ON);
    tone_en      = (state_q == ON) && (state_d == ON);
    active       = (state_q != IDLE);
    dbg_state    = state_q;
  end

  tone_div #(
    .TONE_W(TONE_W)
  ) u_tone_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (tone_restart),
    .en         (tone_en),
    .half       (half),
    .tone       (tone),
    .period_end (period_end)
  );

  assign beep_out = tone;

endmodule

// File: tb/tb_beep_cadence.sv
// Scoreboard bench for beep_cadence: expected {active, beep_out} per cycle is queued
// from hand-derived tone/cadence waveforms and compared one cycle at a time.
module tb_beep_cadence;
  import beep_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       beep_en;
  logic [2:0] level;
  logic       mode;
  logic       beep_out;
  logic       active;
  logic [1:0] dbg_state;

  logic [1:0] exp_q[$];
  int         n_checks;
  int         n_pass;

  beep_cadence #(
    .ON_CYC   (20),
    .OFF_BASE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .beep_en   (beep_en),
    .level     (level),
    .mode      (mode),
    .beep_out  (beep_out),
    .active    (active),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // push n samples of {active, beep}
  task automatic push(input logic b, input logic a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a, b});
  endtask

  // full tone periods: half cycles high then half low, alarm active throughout
  task automatic push_tone(input int half, input int periods);
    for (int p = 0; p < periods; p++) begin
      push(1'b1, 1'b1, half);
      push(1'b0, 1'b1, half);
    end
  endtask

  task automatic drain(input string tag);
    logic [1:0] e;
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      check(tag, {30'd0, active, beep_out}, {30'd0, e});
    end
  endtask

  task automatic stop_and_check(input string tag);
    beep_en = 1'b0;
    push(1'b0, 1'b0, 1);
    drain(tag);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    beep_en  = 1'b0;
    level    = 3'd0;
    mode     = 1'b0;

    #12;
    check("rst_beep", {31'd0, beep_out}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    step();

    // level 6: half 2, period 4
    beep_en = 1'b1; level = 3'd6; mode = 1'b0;
    push_tone(2, 3);
    drain("lvl6");
    stop_and_check("lvl6_stop");

    // level 1: half 7, period 14
    beep_en = 1'b1; level = 3'd1;
    push_tone(7, 2);
    drain("lvl1");
    stop_and_check("lvl1_stop");

    // level 7 saturates to 6
    beep_en = 1'b1; level = 3'd7;
    push_tone(2, 2);
    drain("lvl7");
    stop_and_check("lvl7_stop");

    // level 3 -> 5 two cycles into the first high phase
    beep_en = 1'b1; level = 3'd3;
    push(1'b1, 1'b1, 2);
    drain("chg_pre");
    level = 3'd5;
    push(1'b1, 1'b1, 3);
    push(1'b0, 1'b1, 5);
    push_tone(3, 2);
    drain("chg_post");
    stop_and_check("chg_stop");

    // cadence at level 3: 20 on (period 10), 4 off, then repeats; drop enable during OFF
    beep_en = 1'b1; level = 3'd3; mode = 1'b1;
    push_tone(5, 2);
    push(1'b0, 1'b1, 4);
    push_tone(5, 2);
    push(1'b0, 1'b1, 2);
    drain("cad");
    stop_and_check("cad_off_stop");
    mode = 1'b0;

    // drop enable during a high phase
    beep_en = 1'b1; level = 3'd6;
    push(1'b1, 1'b1, 1);
    drain("hi_pre");
    stop_and_check("hi_stop");

    // level 0 is silent, then level 2 starts with period 12
    beep_en = 1'b1; level = 3'd0;
    push(1'b0, 1'b0, 3);
    drain("lvl0");
    level = 3'd2;
    push_tone(6, 2);
    drain("lvl2");
    stop_and_check("lvl2_stop");

    // asynchronous reset mid-tone, then a fresh start
    beep_en = 1'b1; level = 3'd6;
    push(1'b1, 1'b1, 2);
    push(1'b0, 1'b1, 1);
    drain("arst_pre");
    #2 rst_n = 1'b0;
    #1;
    check("arst_beep", {31'd0, beep_out}, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    step();
    check("arst_hold", {30'd0, active, beep_out}, 32'd0);
    #3 rst_n = 1'b1;
    push_tone(2, 2);
    drain("arst_post");
    stop_and_check("arst_stop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
